// File: rtl/step_dir_pkg.sv
// Shared constants and qualifier state encoding for the step/dir decoder.
package step_dir_pkg;
  localparam int POS_W_DEF = 16;
  localparam int PER_W_DEF = 16;
  localparam int FILT_DEF  = 3;

  typedef enum logic [1:0] {ST_LOW, ST_QUAL, ST_HIGH} qual_state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction decoder: glitch-filtered step qualification, wrapping position
// counter, saturating step-period measurement and snapshot registers.
module step_dir_decoder
  import step_dir_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int PER_W = PER_W_DEF,
  parameter int FILT  = FILT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             clr,
  input  logic             snap,
  output logic [POS_W-1:0] pos,
  output logic [PER_W-1:0] period,
  output logic             snap_valid,
  output logic             step_evt,
  output logic             stall
);
  localparam logic [3:0]       FILT_L  = 4'(FILT);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic step_s, dir_s;

  sync_2ff u_sync_step (.clk(clk), .rst_n(rst_n), .d(step_in), .q(step_s));
  sync_2ff u_sync_dir  (.clk(clk), .rst_n(rst_n), .d(dir_in),  .q(dir_s));

  qual_state_e state;
  logic [3:0]  filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOW;
      filt_cnt <= 4'd0;
      step_evt <= 1'b0;
    end else begin
      step_evt <= 1'b0;
      case (state)
        ST_LOW: if (step_s) begin
          filt_cnt <= 4'd1;
          if (FILT_L == 4'd1) begin
            state    <= ST_HIGH;
            step_evt <= 1'b1;
          end else begin
            state <= ST_QUAL;
          end
        end
        ST_QUAL: if (!step_s) begin
          state <= ST_LOW;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
          if (filt_cnt + 4'd1 == FILT_L) begin
            state    <= ST_HIGH;
            step_evt <= 1'b1;
          end
        end
        ST_HIGH: if (!step_s) state <= ST_LOW;
        default: state <= ST_LOW;
      endcase
    end
  end

  logic [POS_W-1:0] pos_q, pos_nxt;
  logic [PER_W-1:0] per_cnt, per_cnt_nxt, per_reg, per_reg_nxt;

  // Next-state values feed both the live registers and the snapshot, so a
  // snap coinciding with step_evt or clr captures the updated result.
  always_comb begin
    pos_nxt = clr ? '0 : pos_q;
    if (step_evt) pos_nxt = dir_s ? pos_nxt - POS_ONE : pos_nxt + POS_ONE;
    per_reg_nxt = step_evt ? per_cnt : per_reg;
    if (step_evt)                per_cnt_nxt = PER_ONE;
    else if (per_cnt == PER_MAX) per_cnt_nxt = per_cnt;
    else                         per_cnt_nxt = per_cnt + PER_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      per_cnt    <= PER_MAX;
      per_reg    <= '0;
      pos        <= '0;
      period     <= '0;
      snap_valid <= 1'b0;
    end else begin
      pos_q      <= pos_nxt;
      per_cnt    <= per_cnt_nxt;
      per_reg    <= per_reg_nxt;
      snap_valid <= snap;
      if (snap) begin
        pos    <= pos_nxt;
        period <= per_reg_nxt;
      end
    end
  end

  assign stall = (per_cnt == PER_MAX);
endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench: a 16/16 decoder and a 4/8 decoder share one stimulus
// stream so position wrap is exercised on the narrow instance.
module tb_step_dir_decoder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic step_in = 1'b0, dir_in = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [15:0] pos_w, period_w;
  logic [3:0]  pos_n;
  logic [7:0]  period_n;
  logic sv_w, sv_n, evt_w, evt_n, stall_w, stall_n;

  int checks = 0, errors = 0;
  int evt_cnt_w = 0, evt_cnt_n = 0;

  typedef struct { int p; int q; } exp_t;
  exp_t qw[$], qn[$];
  exp_t ew, en;

  always #5 clk = ~clk;

  step_dir_decoder #(.POS_W(16), .PER_W(16), .FILT(3)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .step_in(step_in), .dir_in(dir_in), .clr(clr), .snap(snap),
    .pos(pos_w), .period(period_w), .snap_valid(sv_w), .step_evt(evt_w), .stall(stall_w));

  step_dir_decoder #(.POS_W(4), .PER_W(8), .FILT(3)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .step_in(step_in), .dir_in(dir_in), .clr(clr), .snap(snap),
    .pos(pos_n), .period(period_n), .snap_valid(sv_n), .step_evt(evt_n), .stall(stall_n));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    repeat (hi) tick();
    step_in = 1'b0;
    repeat (lo) tick();
  endtask

  // period expectation of -1 means the spacing is irregular and not checked
  task automatic snap_req(input int pw, input int qw_e, input int pn, input int qn_e);
    qw.push_back('{pw, qw_e});
    qn.push_back('{pn, qn_e});
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick(); tick();
  endtask

  // monitor: counts step events and scores every snapshot as it appears
  always @(negedge clk) begin
    if (evt_w) evt_cnt_w++;
    if (evt_n) evt_cnt_n++;
    if (sv_w) begin
      if (qw.size() == 0) chk("wide_unexpected_snap", 1, 0);
      else begin
        ew = qw.pop_front();
        chk("wide_pos", $signed(pos_w), ew.p);
        if (ew.q >= 0) chk("wide_period", int'(period_w), ew.q);
      end
    end
    if (sv_n) begin
      if (qn.size() == 0) chk("narrow_unexpected_snap", 1, 0);
      else begin
        en = qn.pop_front();
        chk("narrow_pos", $signed(pos_n), en.p);
        if (en.q >= 0) chk("narrow_period", int'(period_n), en.q);
      end
    end
  end

  initial begin
    int e0w, e0n;
    bit found;

    repeat (3) tick();
    chk("rst_pos", int'(pos_w), 0);
    chk("rst_period", int'(period_w), 0);
    chk("rst_snap_valid", int'(sv_w), 0);
    chk("rst_step_evt", int'(evt_w), 0);
    chk("rst_stall_w", int'(stall_w), 1);
    chk("rst_stall_n", int'(stall_n), 1);
    rst_n = 1'b1;
    repeat (3) tick();

    // first step after reset reports the saturated period
    pulse(5, 195);
    snap_req(1, 65535, 1, 255);
    repeat (9) pulse(5, 195);
    snap_req(10, 200, -6, 200);
    chk("evt_count_up_w", evt_cnt_w, 10);
    chk("evt_count_up_n", evt_cnt_n, 10);

    dir_in = 1'b1;
    repeat (5) tick();
    e0w = evt_cnt_w; e0n = evt_cnt_n;
    repeat (3) pulse(5, 195);
    snap_req(7, 200, 7, 200);
    chk("evt_count_down_w", evt_cnt_w - e0w, 3);
    chk("evt_count_down_n", evt_cnt_n - e0n, 3);

    // two-cycle glitch is rejected
    e0w = evt_cnt_w;
    pulse(2, 50);
    snap_req(7, 200, 7, 200);
    chk("glitch_no_evt", evt_cnt_w - e0w, 0);

    // narrow instance wraps 7 -> -8
    dir_in = 1'b0;
    repeat (5) tick();
    pulse(5, 195);
    snap_req(8, -1, -8, -1);

    // clr, dir=1 step_evt and snap all in one cycle
    dir_in = 1'b1;
    repeat (5) tick();
    step_in = 1'b1;
    repeat (5) tick();
    chk("clr_cycle_evt", int'(evt_w), 1);
    qw.push_back('{-1, -1});
    qn.push_back('{-1, -1});
    clr = 1'b1; snap = 1'b1;
    tick();
    clr = 1'b0; snap = 1'b0; step_in = 1'b0;
    repeat (50) tick();

    // long idle saturates the period counter
    repeat (70000) tick();
    chk("idle_stall_w", int'(stall_w), 1);
    chk("idle_stall_n", int'(stall_n), 1);
    step_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (evt_w) found = 1'b1;
    end
    chk("stall_step_seen", int'(found), 1);
    chk("stall_during_evt", int'(stall_w), 1);
    @(negedge clk);
    chk("stall_after_evt_w", int'(stall_w), 0);
    chk("stall_after_evt_n", int'(stall_n), 0);
    tick();
    step_in = 1'b0;
    repeat (20) tick();
    snap_req(-2, 65535, -2, 255);

    // reset while qualifying discards the pending step
    e0w = evt_cnt_w;
    step_in = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0; step_in = 1'b0;
    repeat (2) tick();
    chk("qual_rst_pos", int'(pos_w), 0);
    chk("qual_rst_stall", int'(stall_w), 1);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("qual_rst_no_evt", evt_cnt_w - e0w, 0);
    snap_req(0, 0, 0, 0);

    repeat (5) tick();
    chk("wide_snaps_outstanding", qw.size(), 0);
    chk("narrow_snaps_outstanding", qn.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 Parameter POS_W, default 16: position counter width, signed two's complement.
REQ-002 Parameter PER_W, default 16: step-period counter width, unsigned.
REQ-003 Parameter FILT, default 3: consecutive synchronized-high cycles required to accept a step (range 1..15).
REQ-004 Port clk, input, 1: single clock; all state SHALL be in this domain.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port step_in, input, 1: asynchronous step pulse from the DDA pulse generator.
REQ-007 Port dir_in, input, 1: asynchronous direction; 0 = increment, 1 = decrement.
REQ-008 Port clr, input, 1: synchronous clear of the position counter.
REQ-009 Port snap, input, 1: snapshot request, sampled every cycle.
REQ-010 Port pos, output, POS_W: position captured at the last snapshot.
REQ-011 Port period, output, PER_W: cycles between the last two accepted steps, captured at the last snapshot.
REQ-012 Port snap_valid, output, 1: one-cycle pulse when pos and period are updated.
REQ-013 Port step_evt, output, 1: one-cycle pulse per accepted step.
REQ-014 Port stall, output, 1: high while the period counter is saturated.

Function
REQ-015 step_in and dir_in SHALL each pass through a 2-flop synchronizer before use.
REQ-016 The qualifier FSM SHALL have states LOW, QUAL and HIGH.
REQ-017 LOW -> QUAL when synchronized step is 1; the filter counter loads 1.
REQ-018 In QUAL, step=1 increments the filter counter; when it reaches FILT, the FSM goes to HIGH and step_evt pulses in that cycle.
REQ-019 In QUAL, step=0 SHALL return the FSM to LOW with no step_evt (glitch rejected).
REQ-020 HIGH -> LOW when synchronized step is 0; exactly one step_evt SHALL occur per accepted pulse.
REQ-021 With FILT=3, step_evt SHALL assert on the 5th rising clk edge after step_in is first sampled high.
REQ-022 On step_evt, the internal position SHALL add +1 (dir=0) or -1 (dir=1), using synchronized dir in that cycle.
REQ-023 Position arithmetic SHALL wrap modulo 2^POS_W (max+1 -> min, min-1 -> max).
REQ-024 clr SHALL set the internal position to 0; on clr and step_evt in the same cycle, the result is +1 or -1.
REQ-025 The period counter SHALL increment each cycle, saturating at 2^PER_W-1.
REQ-026 On step_evt, the internal period register SHALL take the counter value and the counter SHALL reload to 1.
REQ-027 stall SHALL equal (period counter == 2^PER_W-1).
REQ-028 On snap, pos and period SHALL be loaded at the next clk edge; snap_valid SHALL pulse in the cycle they change.
REQ-029 A snapshot SHALL include any step_evt or clr in the same cycle as snap.
REQ-030 Back-to-back snap cycles SHALL each produce a snap_valid pulse.

Reset
REQ-031 On rst_n low, all outputs SHALL be cleared asynchronously: pos, period, snap_valid and step_evt to 0.
REQ-032 On rst_n low, synchronizers, FSM and position SHALL clear (FSM to LOW); the period counter SHALL be set to saturated, so stall=1.
REQ-033 Reset asserted during QUAL SHALL discard the pending step with no step_evt.
REQ-034 The first step after reset SHALL report period = 2^PER_W-1.

Structure
REQ-035 Package step_dir_pkg SHALL hold the FSM state enum and the default POS_W, PER_W and FILT constants.
REQ-036 A sub-module sync_2ff SHALL implement the synchronizer and be instantiated for step_in and dir_in.

Verification (FILT=3, POS_W=PER_W=16)
REQ-037 10 pulses with dir=0, 5 cycles high, 200-cycle spacing, then snap -> pos=10, period=200, single snap_valid.
REQ-038 From pos=10, 3 pulses with dir=1 -> snapshot pos=7; 3 step_evt pulses total.
REQ-039 step_in high for 2 cycles -> no step_evt, pos unchanged.
REQ-040 Position 32767 plus one dir=0 step -> snapshot pos=-32768; clr with a dir=1 step in the same cycle -> pos=-1.
REQ-041 70000 idle cycles -> stall=1; the next step gives period=65535 and stall drops the cycle after step_evt.
REQ-042 rst_n pulsed during QUAL -> no step_evt, pos=0, stall=1.
